// File: rtl/tag_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tag_mem_sequencer
//  Description : Sequences a single-port tag word memory (EPC/USER banks)
//                between a serial TX readout and packet-parse word writes.
//                Handles prefetch, fetch/write arbitration, bank/pointer
//                address generation and readout range checking.
//  Revision    : 1.0  initial release
// ============================================================================
module tag_mem_sequencer #(
  parameter int         ADDR_W    = 10,
  parameter int         EPC_WORDS = 8,
  parameter logic [1:0] EPC_BANK  = 2'b01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_start,
  input  logic [1:0]        src_sel,
  input  logic [1:0]        rw_bank,
  input  logic [7:0]        rw_ptr,
  input  logic [7:0]        rw_words,
  input  logic              membitclk,
  output logic              membitsrc,
  output logic              memdatadone,
  input  logic              wr_req,
  input  logic [15:0]       wr_data,
  output logic              wr_ack,
  output logic              wr_ovf,
  output logic              err_range,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [15:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [9:0]  base_q, base_d;          // {bank, ptr} of the first word
  logic [8:0]  len_q, len_d;            // words in the session (1..256)
  logic [8:0]  widx_q, widx_d;          // index of the next word to fetch
  logic [15:0] shift_q, shift_d;        // serial output word, MSB first
  logic [3:0]  bcnt_q, bcnt_d;          // bits already shifted out of shift_q
  logic [15:0] pf_buf_q, pf_buf_d;      // prefetched next word
  logic        pf_valid_q, pf_valid_d;  // pf_buf_q holds a word
  logic        pf_fly_q, pf_fly_d;      // prefetch read issued last cycle
  logic        err_q, err_d;
  logic        pend_q, pend_d;          // one-deep write slot
  logic [9:0]  pend_addr_q, pend_addr_d;
  logic [15:0] pend_data_q, pend_data_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  sync_q;                  // [1:0] synchronizer, [2] previous level

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic        bit_adv;
  logic        fetch_go;
  logic        write_go;
  logic        words_left;
  logic [9:0]  fetch_addr;
  logic [9:0]  req_base;
  logic [8:0]  req_len;
  logic [9:0]  req_end;
  logic        req_err;
  logic        req_mem;

  // Rising edge of the synchronized bit clock marks one consumed bit.
  assign bit_adv    = sync_q[1] & ~sync_q[2];
  assign words_left = (widx_q < len_q);
  assign fetch_addr = base_q + {1'b0, widx_q};

  // Bit clock synchronizer and edge-detect history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], membitclk};
    end
  end

  // Decode the session requested by tx_start and check its range.
  always_comb begin
    req_base = 10'd0;
    req_len  = 9'd0;
    req_mem  = 1'b0;
    if (src_sel == 2'd1) begin
      req_base = {EPC_BANK, 8'd0};
      req_len  = 9'(EPC_WORDS);
      req_mem  = 1'b1;
    end else if (src_sel == 2'd2) begin
      req_base = {rw_bank, rw_ptr};
      // Zero words means "through the end of the bank".
      req_len  = (rw_words == 8'd0) ? (9'd256 - {1'b0, rw_ptr}) : {1'b0, rw_words};
      req_mem  = 1'b1;
    end
    req_end = {2'b00, req_base[7:0]} + {1'b0, req_len};
    req_err = (req_end > 10'd256);
  end

  // Readout FSM: next state, fetch/prefetch issue and shift datapath.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    widx_d     = widx_q;
    shift_d    = shift_q;
    bcnt_d     = bcnt_q;
    pf_buf_d   = pf_buf_q;
    pf_valid_d = pf_valid_q;
    pf_fly_d   = pf_fly_q;
    err_d      = err_q;
    fetch_go   = 1'b0;

    // A prefetch read returns one cycle after it was issued.
    if (pf_fly_q) begin
      pf_buf_d   = mem_rdata;
      pf_valid_d = 1'b1;
      pf_fly_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_FETCH: begin
        fetch_go = 1'b1;
        widx_d   = widx_q + 9'd1;
        state_d  = S_LOAD;
      end
      S_LOAD: begin
        shift_d = mem_rdata;
        bcnt_d  = 4'd0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // Keep the next word staged as early as possible.
        if (!pf_valid_q && !pf_fly_q && words_left) begin
          fetch_go = 1'b1;
          pf_fly_d = 1'b1;
          widx_d   = widx_q + 9'd1;
        end
        if (bit_adv) begin
          if (bcnt_q != 4'd15) begin
            shift_d = {shift_q[14:0], 1'b0};
            bcnt_d  = bcnt_q + 4'd1;
          end else if (pf_valid_q) begin
            shift_d    = pf_buf_q;
            bcnt_d     = 4'd0;
            pf_valid_d = 1'b0;
          end else if (!(pf_fly_q || words_left)) begin
            state_d = S_DONE;
          end
          // Otherwise the next word is not staged yet: hold the current bit.
        end
      end
      S_DONE: begin
        if (src_sel != 2'd1 && src_sel != 2'd2) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new tx_start aborts whatever is in progress.
    if (tx_start) begin
      base_d     = req_base;
      len_d      = req_len;
      widx_d     = 9'd0;
      bcnt_d     = 4'd0;
      pf_valid_d = 1'b0;
      pf_fly_d   = 1'b0;
      err_d      = 1'b0;
      if (!req_mem) begin
        state_d = S_IDLE;
      end else if (req_err) begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  // Write slot: a fetch always wins the port, the write takes the next free cycle.
  always_comb begin
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    ovf_d       = ovf_q;
    write_go    = pend_q && !fetch_go;
    if (write_go) begin
      pend_d = 1'b0;
    end
    if (wr_req) begin
      if (pend_q && !write_go) begin
        ovf_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_addr_d = {rw_bank, rw_ptr};
        pend_data_d = wr_data;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      base_q      <= 10'd0;
      len_q       <= 9'd0;
      widx_q      <= 9'd0;
      shift_q     <= 16'd0;
      bcnt_q      <= 4'd0;
      pf_buf_q    <= 16'd0;
      pf_valid_q  <= 1'b0;
      pf_fly_q    <= 1'b0;
      err_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= 10'd0;
      pend_data_q <= 16'd0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      widx_q      <= widx_d;
      shift_q     <= shift_d;
      bcnt_q      <= bcnt_d;
      pf_buf_q    <= pf_buf_d;
      pf_valid_q  <= pf_valid_d;
      pf_fly_q    <= pf_fly_d;
      err_q       <= err_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      ovf_q       <= ovf_d;
    end
  end

  // Output decode; everything idles at zero when nothing is active.
  always_comb begin
    membitsrc   = (state_q == S_SHIFT) ? shift_q[15] : 1'b0;
    memdatadone = (state_q == S_DONE);
    mem_re      = fetch_go;
    mem_we      = write_go;
    wr_ack      = write_go;
    wr_ovf      = ovf_q;
    err_range   = err_q;
    busy        = ((state_q != S_IDLE) && (state_q != S_DONE)) || pend_q;
    mem_wdata   = write_go ? pend_data_q : 16'd0;
    if (fetch_go) begin
      mem_addr = ADDR_W'(fetch_addr);
    end else if (write_go) begin
      mem_addr = ADDR_W'(pend_addr_q);
    end else begin
      mem_addr = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tag_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tag_mem_sequencer
//  Description : Self-checking bench for tag_mem_sequencer with a behavioural
//                synchronous SRAM and a bench-side reference memory image.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tag_mem_sequencer;

  logic        clk;
  logic        reset;
  logic        tx_start;
  logic [1:0]  src_sel;
  logic [1:0]  rw_bank;
  logic [7:0]  rw_ptr;
  logic [7:0]  rw_words;
  logic        membitclk;
  logic        membitsrc;
  logic        memdatadone;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        wr_ovf;
  logic        err_range;
  logic        busy;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;

  logic [15:0] sram    [1024];
  logic [15:0] ref_mem [1024];

  int n_vec  = 0;
  int n_fail = 0;
  int re_cnt = 0;
  logic both_seen = 1'b0;

  tag_mem_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .tx_start   (tx_start),
    .src_sel    (src_sel),
    .rw_bank    (rw_bank),
    .rw_ptr     (rw_ptr),
    .rw_words   (rw_words),
    .membitclk  (membitclk),
    .membitsrc  (membitsrc),
    .memdatadone(memdatadone),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .wr_ovf     (wr_ovf),
    .err_range  (err_range),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM: read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= sram[mem_addr];
    if (mem_re) re_cnt <= re_cnt + 1;
    if (mem_re && mem_we) both_seen <= 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic pulse_bit();
    membitclk = 1'b1;
    repeat (4) @(negedge clk);
    membitclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Pulse tx_start at a negedge and return two clocks after it was sampled.
  task automatic start(input logic [1:0] sel, input logic [1:0] bank,
                       input logic [7:0] ptr, input logic [7:0] words);
    src_sel  = sel;
    rw_bank  = bank;
    rw_ptr   = ptr;
    rw_words = words;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic stream_check(input string tag, input logic [9:0] base, input int n);
    logic [15:0] got;
    logic [9:0]  a;
    logic        early;
    early = 1'b0;
    for (int w = 0; w < n; w++) begin
      got = 16'd0;
      a   = base + 10'(w);
      for (int b = 0; b < 16; b++) begin
        got = {got[14:0], membitsrc};
        if (memdatadone) early = 1'b1;
        pulse_bit();
      end
      chk($sformatf("%s word%0d", tag, w), 64'(got), 64'(ref_mem[a]));
    end
    chk({tag, " done_early"}, 64'(early), 64'd0);
    chk({tag, " done"}, 64'(memdatadone), 64'd1);
  endtask

  function automatic logic [63:0] all_out();
    return 64'({membitsrc, memdatadone, wr_ack, wr_ovf, err_range, busy,
                mem_re, mem_we, mem_addr, mem_wdata});
  endfunction

  typedef struct {
    string      name;
    logic [1:0] sel;
    logic [1:0] bank;
    logic [7:0] ptr;
    logic [7:0] words;
    logic [9:0] exp_base;
    int         exp_n;
    logic       exp_err;
  } vec_t;

  vec_t vt[7];

  initial begin
    int r0;
    logic [15:0] epc_init [8];
    epc_init = '{16'h3000, 16'hE200, 16'h1234, 16'h5678, 16'h9ABC,
                 16'hDEF0, 16'hA55A, 16'h0F0F};
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 16'((i * 40503) ^ 16'h5A5A);
    end
    for (int i = 0; i < 8; i++) ref_mem[10'h100 + i] = epc_init[i];
    for (int i = 0; i < 1024; i++) sram[i] = ref_mem[i];

    vt[0] = '{"epc",        2'd1, 2'd0, 8'h00, 8'd0, 10'h100, 8, 1'b0};
    vt[1] = '{"rd_fe_2",    2'd2, 2'd3, 8'hFE, 8'd2, 10'h3FE, 2, 1'b0};
    vt[2] = '{"rd_fe_3err", 2'd2, 2'd3, 8'hFE, 8'd3, 10'h3FE, 0, 1'b1};
    vt[3] = '{"rd_fc_all",  2'd2, 2'd2, 8'hFC, 8'd0, 10'h2FC, 4, 1'b0};
    vt[4] = '{"rd_10_3",    2'd2, 2'd0, 8'h10, 8'd3, 10'h010, 3, 1'b0};
    vt[5] = '{"rd_100_1",   2'd2, 2'd1, 8'h00, 8'd1, 10'h100, 1, 1'b0};
    vt[6] = '{"rd_ff_all",  2'd2, 2'd0, 8'hFF, 8'd0, 10'h0FF, 1, 1'b0};

    reset = 1'b1; tx_start = 1'b0; src_sel = 2'd0; rw_bank = 2'd0;
    rw_ptr = 8'd0; rw_words = 8'd0; membitclk = 1'b0; wr_req = 1'b0;
    wr_data = 16'd0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out(), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven readout sessions.
    for (int i = 0; i < 7; i++) begin
      r0 = re_cnt;
      start(vt[i].sel, vt[i].bank, vt[i].ptr, vt[i].words);
      chk({vt[i].name, " err_range"}, 64'(err_range), 64'(vt[i].exp_err));
      if (vt[i].exp_err) begin
        chk({vt[i].name, " done"}, 64'(memdatadone), 64'd1);
        repeat (10) @(negedge clk);
        chk({vt[i].name, " bitsrc"}, 64'(membitsrc), 64'd0);
        chk({vt[i].name, " reads"}, 64'(re_cnt - r0), 64'd0);
      end else begin
        stream_check(vt[i].name, vt[i].exp_base, vt[i].exp_n);
        chk({vt[i].name, " reads"}, 64'(re_cnt - r0), 64'(vt[i].exp_n));
        chk({vt[i].name, " busy"}, 64'(busy), 64'd0);
      end
    end

    // Write arriving in the prefetch cycle issues exactly one cycle later.
    start(2'd2, 2'd0, 8'h20, 8'd2);
    chk("wp prefetch_re", 64'({mem_re, mem_addr}), 64'({1'b1, 10'h021}));
    rw_ptr = 8'h80; wr_data = 16'hBEEF; wr_req = 1'b1;
    @(negedge clk);
    wr_req = 1'b0;
    chk("wp write", 64'({mem_we, wr_ack, mem_re, mem_addr, mem_wdata}),
        64'({1'b1, 1'b1, 1'b0, 10'h080, 16'hBEEF}));
    ref_mem[10'h080] = 16'hBEEF;
    @(negedge clk);
    chk("wp single", 64'({mem_we, wr_ack}), 64'd0);
    stream_check("wp stream", 10'h020, 2);
    chk("wp no_ovf", 64'(wr_ovf), 64'd0);

    // Simultaneous tx_start and wr_req, then a second request while pending.
    src_sel = 2'd2; rw_bank = 2'd0; rw_ptr = 8'h80; rw_words = 8'd1;
    wr_data = 16'h1234; wr_req = 1'b1; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0; wr_data = 16'h5555;
    chk("sim fetch_first", 64'({mem_re, mem_we}), 64'({1'b1, 1'b0}));
    @(negedge clk);
    wr_req = 1'b0;
    chk("sim write_next", 64'({mem_we, wr_ack, mem_addr, mem_wdata, wr_ovf}),
        64'({1'b1, 1'b1, 10'h080, 16'h1234, 1'b1}));
    @(negedge clk);
    stream_check("sim old_word", 10'h080, 1);
    ref_mem[10'h080] = 16'h1234;
    start(2'd2, 2'd0, 8'h80, 8'd1);
    stream_check("sim new_word", 10'h080, 1);
    chk("sim ovf_sticky", 64'(wr_ovf), 64'd1);

    // Restart mid-session onto a new base, then abort to IDLE.
    start(2'd1, 2'd0, 8'h00, 8'd0);
    repeat (20) pulse_bit();
    start(2'd2, 2'd2, 8'h10, 8'd2);
    chk("rs first_bit", 64'(membitsrc), 64'(ref_mem[10'h210][15]));
    stream_check("rs stream", 10'h210, 2);
    src_sel = 2'd0; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    @(negedge clk);
    chk("rs idle", 64'({memdatadone, busy}), 64'd0);

    // Reset while streaming word 3.
    start(2'd1, 2'd0, 8'h00, 8'd0);
    repeat (53) pulse_bit();
    chk("rst busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("rst outputs", all_out(), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    r0 = re_cnt;
    repeat (20) @(negedge clk);
    chk("rst no_reads", 64'(re_cnt - r0), 64'd0);
    chk("rst idle", 64'({memdatadone, busy, wr_ovf}), 64'd0);

    chk("re_we_exclusive", 64'(both_seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tag_mem_sequencer.md
Name: tag_mem_sequencer

Overview:
- Sequences the tag's single-port word memory (EPC/USER banks) between two requesters.
  - Serial TX readout: drives membitsrc and memdatadone, and advances on membitclk from the sequencer mux.
  - Packet-parse word writes: writedataout qualified by epc_data_ready.
- Sits between top-level memory IO and an external synchronous SRAM macro.
- Owns prefetch, arbitration, bank/pointer address generation and range checking.

Parameters:
- ADDR_W, 10, SRAM word address width; address = {bank[1:0], ptr[7:0]}.
- EPC_WORDS, 8, words streamed for an EPC readout (PC + 112-bit EPC).
- EPC_BANK, 2'b01, bank used for EPC readout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- tx_start  in  1  one-cycle pulse; starts a readout session.
- src_sel  in  2  bitsrcselect: 1 = EPC, 2 = READ, 0/3 = no memory session.
- rw_bank  in  2  readwritebank.
- rw_ptr  in  8  readwriteptr, word pointer within bank.
- rw_words  in  8  readwords; 0 = to end of bank.
- membitclk  in  1  serial bit clock from TX mux (asynchronous to clk).
- membitsrc  out  1  current serial bit, MSB of word first.
- memdatadone  out  1  all session bits consumed.
- wr_req  in  1  epc_data_ready pulse.
- wr_data  in  16  writedataout.
- wr_ack  out  1  one-cycle pulse, same cycle as mem_we.
- wr_ovf  out  1  sticky: write request lost.
- err_range  out  1  readout range invalid.
- busy  out  1  readout session active or write pending.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  16  SRAM write data.
- mem_we  out  1  SRAM write strobe.
- mem_re  out  1  SRAM read strobe.
- mem_rdata  in  16  SRAM read data, valid the cycle after mem_re.

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM IDLE, pending write cleared, wr_ovf cleared.
- membitclk path:
  - 2-flop synchronizer, then rising-edge detect gives bit_adv (1 clk pulse).
  - membitclk high/low phases must each be ≥ 4 clk.
- Session setup on tx_start (sampled in any state; a restart aborts any active session):
  - src_sel=1: base = {EPC_BANK, 8'd0}, len = EPC_WORDS.
  - src_sel=2: base = {rw_bank, rw_ptr}, len = rw_words, or 256-rw_ptr when rw_words=0.
  - src_sel=0/3: go to IDLE, memdatadone=0.
- Range check: if rw_ptr + len > 256 (9-bit sum), set err_range=1 and enter DONE immediately. In this case membitsrc=0 and no reads are issued.
- err_range clears on the next tx_start.
- FSM states: IDLE -> FETCH -> LOAD -> SHIFT -> DONE.
  - FETCH: mem_re=1, mem_addr = base + word_idx.
  - LOAD: shift_reg <= mem_rdata; membitsrc = shift_reg[15] from the following cycle. First valid bit appears 2 clk after tx_start.
  - SHIFT:
    - Each bit_adv shifts left and increments bit_cnt (4-bit).
    - Next word is prefetched into prefetch_buf as soon as a word is loaded and words remain.
    - On bit_adv with bit_cnt=15: if words remain, load prefetch_buf; else go to DONE.
  - DONE: memdatadone=1, membitsrc=0; hold until tx_start or src_sel leaves 1/2. Either then returns to IDLE.
- Write path:
  - wr_req latches {rw_bank, rw_ptr, wr_data} into a 1-deep pending register.
  - A wr_req arriving while a write is already pending is dropped and sets wr_ovf.
- Arbitration per cycle: a readout fetch (FETCH or prefetch) has priority over a pending write.
  - A pending write issues mem_we=1 on the first cycle with no fetch, with wr_ack=1 that cycle.
  - mem_re and mem_we are never both 1.
  - A write stalls at most 1 cycle per fetched word.
- Simultaneous tx_start and wr_req: both are accepted. The fetch goes first; the write issues the next cycle.
- bit_adv in IDLE/DONE is ignored.
- bit_adv arriving before LOAD completes is a timing violation; the block holds the current bit and does not skip.
- busy = (state != IDLE && state != DONE) || write pending.

Test Plan:
- Reset mid-SHIFT (reset=0 while streaming word 3) -> all outputs 0 immediately; after release, IDLE; no mem_re until next tx_start.
- EPC readout: SRAM EPC bank = 16'h3000, 16'hE200, ...; tx_start with src_sel=1, then 128 membitclk edges -> membitsrc reproduces 8 words MSB-first. memdatadone rises after edge 128, not before.
- READ range: rw_bank=3, rw_ptr=8'hFE, rw_words=2 -> streams words 0x3FE, 0x3FF. rw_ptr=8'hFE, rw_words=3 -> err_range=1, memdatadone=1, zero mem_re.
- rw_words=0, rw_ptr=8'hFC -> exactly 4 words (64 bits), then memdatadone.
- Write during streaming: wr_req on the same cycle as a prefetch -> mem_we exactly 1 cycle later, wr_ack pulse, streamed bits unaffected. A second wr_req while pending -> wr_ovf=1, stays 1 until reset.
- Restart: tx_start mid-session with src_sel=2 -> old session aborted, first bit of the new base word within 2 clk; tx_start with src_sel=0 -> IDLE, memdatadone=0.
